// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared PCI initiator commands, status codes, FSM states and parity helper
package pci_pkg;

   localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
   localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
   localparam logic [3:0] BE_IDLE       = 4'b1111;

   typedef enum logic [1:0] {
      ST_OK     = 2'b00,
      ST_MABORT = 2'b01
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ABORT,
      S_TURN
   } state_t;

   function automatic logic even_par(input logic [35:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/pci_par_gen.sv
// rtl/pci_par_gen.sv - registered even parity over AD/CBE, zero when the initiator is not driving AD
module pci_par_gen
   import pci_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ad,
   input  logic [3:0]  cbe,
   input  logic        drive,
   output logic        par
);

   // PAR trails the AD/CBE values it covers by one clock
   always_ff @(posedge clock) begin
      if (reset)
         par <= 1'b0;
      else
         par <= drive ? even_par({ad, cbe}) : 1'b0;
   end

endmodule

// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - PCI bus master running host memory bursts; PAR output under PCI_INIT_PAR_EN
module pci_initiator
   import pci_pkg::*;
#(
   parameter  int MAX_BURST      = 8,
   parameter  int DEVSEL_TIMEOUT = 5,
   localparam int LEN_W          = $clog2(MAX_BURST + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cmd,
   input  logic [31:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   input  logic [3:0]       req_be,
   input  logic [31:0]      wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic [1:0]       status,
   output logic             FRAME,
   output logic             IRDY,
   output logic [3:0]       CBE,
   output logic [31:0]      AD_out,
   output logic             AD_oe,
   input  logic [31:0]      AD_in,
   input  logic             DEVSEL,
   input  logic             TRDY
`ifdef PCI_INIT_PAR_EN
   ,
   output logic             PAR
`endif
);

   localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

   state_t           state, state_n;
   logic             is_write, is_write_n;
   logic [3:0]       be_q, be_n;
   logic [LEN_W-1:0] len_q, len_n, rem_q, rem_n, loaded_q, loaded_n, len_eff;
   logic             stage_full, stage_full_n, devsel_seen, devsel_seen_n, aborted, aborted_n;
   logic [CNT_W-1:0] dev_cnt, dev_cnt_n;
   logic             req_ready_n, rd_valid_n, done_n, frame_n, irdy_n, ad_oe_n;
   logic [31:0]      rd_data_n, ad_out_n;
   logic [1:0]       status_n;
   logic [3:0]       cbe_n;
   logic             in_bus, completing, abort_now, load;

   assign len_eff    = (req_len == '0) ? LEN_W'(1) :
                       (req_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : req_len;
   assign in_bus     = (state == S_ADDR) || (state == S_DATA);
   assign completing = (state == S_DATA) && !IRDY && !TRDY && !DEVSEL;
   assign abort_now  = in_bus && DEVSEL &&
                       (devsel_seen || (dev_cnt == CNT_W'(DEVSEL_TIMEOUT - 1)));
   // wr_ready looks at this cycle's TRDY/DEVSEL so the stage can refill on the completing edge
   assign wr_ready   = !reset && is_write && in_bus && !abort_now &&
                       (loaded_q < len_q) && (!stage_full || completing);
   assign load       = wr_valid && wr_ready;

   // Next-state and next-output decode for the bus sequencer
   always_comb begin
      state_n       = state;
      is_write_n    = is_write;
      be_n          = be_q;
      len_n         = len_q;
      rem_n         = rem_q;
      loaded_n      = loaded_q;
      stage_full_n  = stage_full;
      devsel_seen_n = devsel_seen;
      aborted_n     = aborted;
      dev_cnt_n     = dev_cnt;
      req_ready_n   = req_ready;
      rd_valid_n    = 1'b0;
      rd_data_n     = rd_data;
      done_n        = 1'b0;
      status_n      = status;
      frame_n       = FRAME;
      irdy_n        = IRDY;
      cbe_n         = CBE;
      ad_out_n      = AD_out;
      ad_oe_n       = AD_oe;
      if (in_bus && !devsel_seen) dev_cnt_n = dev_cnt + CNT_W'(1);
      if (in_bus && !DEVSEL) devsel_seen_n = 1'b1;
      case (state)
         S_IDLE: begin
            req_ready_n = 1'b1;
            if (req_valid && req_ready) begin
               state_n       = S_ADDR;
               req_ready_n   = 1'b0;
               is_write_n    = req_cmd[0];
               be_n          = req_be;
               len_n         = len_eff;
               rem_n         = len_eff;
               loaded_n      = '0;
               stage_full_n  = 1'b0;
               devsel_seen_n = 1'b0;
               aborted_n     = 1'b0;
               dev_cnt_n     = '0;
               frame_n       = 1'b0;
               irdy_n        = 1'b1;
               ad_oe_n       = 1'b1;
               ad_out_n      = req_addr;
               cbe_n         = req_cmd;
            end
         end
         S_ADDR, S_DATA: begin
            if (abort_now) begin
               state_n      = S_ABORT;
               frame_n      = 1'b1;
               irdy_n       = 1'b0;
               stage_full_n = 1'b0;
               aborted_n    = 1'b1;
            end else if (completing && rem_q == LEN_W'(1)) begin
               rem_n        = '0;
               if (!is_write) begin
                  rd_valid_n = 1'b1;
                  rd_data_n  = AD_in;
               end
               state_n      = S_TURN;
               frame_n      = 1'b1;
               irdy_n       = 1'b1;
               ad_oe_n      = 1'b0;
               ad_out_n     = '0;
               cbe_n        = BE_IDLE;
               stage_full_n = 1'b0;
            end else begin
               state_n = S_DATA;
               cbe_n   = be_q;
               if (completing) begin
                  rem_n = rem_q - LEN_W'(1);
                  if (!is_write) begin
                     rd_valid_n = 1'b1;
                     rd_data_n  = AD_in;
                  end
               end
               if (is_write) begin
                  // IRDY tracks whether a word is sitting on AD_out
                  stage_full_n = load || (stage_full && !completing);
                  irdy_n       = !stage_full_n;
                  if (load) begin
                     ad_out_n = wr_data;
                     loaded_n = loaded_q + LEN_W'(1);
                     if (loaded_q + LEN_W'(1) == len_q) frame_n = 1'b1;
                  end
               end else begin
                  ad_oe_n = 1'b0;
                  irdy_n  = 1'b0;
                  if (state == S_ADDR)
                     frame_n = (len_q == LEN_W'(1));
                  else if (completing && rem_q == LEN_W'(2))
                     frame_n = 1'b1;
               end
            end
         end
         S_ABORT: begin
            state_n  = S_TURN;
            irdy_n   = 1'b1;
            ad_oe_n  = 1'b0;
            ad_out_n = '0;
            cbe_n    = BE_IDLE;
         end
         S_TURN: begin
            state_n     = S_IDLE;
            done_n      = 1'b1;
            status_n    = aborted ? ST_MABORT : ST_OK;
            req_ready_n = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and registered bus/host outputs; reset releases the bus immediately
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         is_write    <= 1'b0;
         be_q        <= BE_IDLE;
         len_q       <= '0;
         rem_q       <= '0;
         loaded_q    <= '0;
         stage_full  <= 1'b0;
         devsel_seen <= 1'b0;
         aborted     <= 1'b0;
         dev_cnt     <= '0;
         req_ready   <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         done        <= 1'b0;
         status      <= ST_OK;
         FRAME       <= 1'b1;
         IRDY        <= 1'b1;
         CBE         <= BE_IDLE;
         AD_out      <= '0;
         AD_oe       <= 1'b0;
      end else begin
         state       <= state_n;
         is_write    <= is_write_n;
         be_q        <= be_n;
         len_q       <= len_n;
         rem_q       <= rem_n;
         loaded_q    <= loaded_n;
         stage_full  <= stage_full_n;
         devsel_seen <= devsel_seen_n;
         aborted     <= aborted_n;
         dev_cnt     <= dev_cnt_n;
         req_ready   <= req_ready_n;
         rd_valid    <= rd_valid_n;
         rd_data     <= rd_data_n;
         done        <= done_n;
         status      <= status_n;
         FRAME       <= frame_n;
         IRDY        <= irdy_n;
         CBE         <= cbe_n;
         AD_out      <= ad_out_n;
         AD_oe       <= ad_oe_n;
      end
   end

`ifdef PCI_INIT_PAR_EN
   pci_par_gen u_par_gen (
      .clock (clock),
      .reset (reset),
      .ad    (AD_out),
      .cbe   (CBE),
      .drive (AD_oe),
      .par   (PAR)
   );
`endif

endmodule

// File: doc/pci_initiator.md
# pci_initiator

PCI bus initiator (master) that sits directly upstream of the target device on the shared PCI bus. It accepts single- or multi-word memory read/write requests from a local host port and runs them as PCI bursts. It drives FRAME/IRDY/CBE/AD, follows the target's DEVSEL/TRDY handshake, and returns read data and completion status to the host. It terminates with a master abort when no target claims the address.

## Interface
Parameters:
- MAX_BURST, 8, maximum data phases per transaction; LEN_W = $clog2(MAX_BURST+1)
- DEVSEL_TIMEOUT, 5, clocks after address phase to wait for DEVSEL before master abort

Ports:
- clock  in  1  single clock; all bus signals change and are sampled on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid / req_ready  in / out  1  host request handshake; accepted when both high
- req_cmd  in  4  PCI command; cmd[0]=1 write, 0 read (0111 mem write, 0110 mem read)
- req_addr  in  32  start address
- req_len  in  LEN_W  number of data phases
- req_be  in  4  active-low byte enables used for every data phase
- wr_data  in  32, wr_valid  in  1, wr_ready  out  1  write-data stream
- rd_data  out  32, rd_valid  out  1  read-data stream, no backpressure
- done  out  1  one-cycle pulse at transaction end
- status  out  2  00 OK, 01 master abort; held until next done
- FRAME  out  1  active low
- IRDY  out  1  active low
- CBE  out  4  command in address phase, byte enables in data phases
- AD_out  out  32, AD_oe  out  1, AD_in  in  32  split AD bus; top level tristates AD = AD_oe ? AD_out : z
- DEVSEL  in  1  active low
- TRDY  in  1  active low
- PAR  out  1  present only with PCI_INIT_PAR_EN

## Operation
- FSM: IDLE -> ADDR -> DATA -> TURN -> IDLE.
- IDLE: req_ready=1. On accept, latch cmd/addr/len/be. req_len=0 runs as 1; values above MAX_BURST are clamped to MAX_BURST.
- ADDR (exactly 1 cycle): FRAME=0, IRDY=1, AD_oe=1, AD_out=addr, CBE=cmd.
- DATA: CBE=req_be. A data phase completes on an edge sampling IRDY=0, TRDY=0, DEVSEL=0. The remaining-phase count decrements per completion.
- Write data path:
  - 1-entry staging register; wr_ready=1 when the stage is empty or completing this edge.
  - IRDY asserted only while a staged word is on AD_out; AD_oe stays 1 throughout DATA.
  - Staged words are never loaded beyond len.
- Read data path:
  - AD_oe=0 from the first DATA cycle (turnaround); IRDY asserted every DATA cycle.
  - On each completion, rd_data=AD_in and rd_valid=1 for one cycle.
- FRAME is deasserted in the same cycle IRDY is asserted for the final data phase and stays high. It never goes high while IRDY is high.
- After the final completion: IRDY=1, AD_oe=0, enter TURN (1 cycle, bus idle), then done=1 and status=00 on entry to IDLE.
- Master abort:
  - The counter starts at the ADDR cycle.
  - If DEVSEL is not sampled low within DEVSEL_TIMEOUT edges, drive FRAME=1 with IRDY=0 for one cycle, then IRDY=1 and AD_oe=0, then TURN.
  - done=1, status=01; pending write words are dropped and wr_ready=0.
- DEVSEL deasserting mid-burst is treated as a master abort at that edge.

## Timing
- Reset values: FRAME=1, IRDY=1, CBE=4'b1111, AD_out=0, AD_oe=0, PAR=0, req_ready=0, wr_ready=0, rd_valid=0, rd_data=0, done=0, status=00. req_ready rises on the first cycle after reset deasserts.
- All outputs are registered.
- Address phase: the cycle following request acceptance.
- First IRDY low: earliest in the cycle after ADDR.
- Zero-wait-state target: one data phase per clock.
- Minimum write latency for N phases: accept, 1 ADDR, N DATA, 1 TURN; done pulses in the cycle after TURN.
- Back-to-back requests: the next acceptance is no earlier than the done cycle, so there is at least one idle bus cycle between transactions.
- Reset asserted mid-transaction releases the bus at that edge (FRAME=IRDY=1, AD_oe=0) with no done pulse.

## Configuration
- PCI_INIT_PAR_EN defined:
  - PAR port exists.
  - PAR = even parity of the AD_out and CBE values driven in the previous cycle, when the initiator drove AD (address phase and write data phases).
  - Otherwise PAR=0.
- Not defined: no PAR port and no parity logic. All other behaviour is identical.

## Structure
- Shared package pci_pkg holds:
  - command constants CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111
  - status codes ST_OK and ST_MABORT
  - FSM state enum
  - the byte-enable idle value 4'b1111
- One sub-module: pci_par_gen (registered 36-bit even-parity generator), instantiated only under PCI_INIT_PAR_EN.

## Test plan
- Write cmd 0111, addr 2, len 4, data 10/10/11/12, target with DEVSEL and TRDY low from the first data phase -> ADDR shows AD=2, CBE=0111; four completions on consecutive edges; FRAME high with the fourth IRDY; done=1, status=00.
- Read cmd 0110, addr 2, len 4, target returns 0xA0..0xA3 -> AD_oe=0 after ADDR; four rd_valid pulses with 0xA0..0xA3 in order; done, status=00.
- Write len 3 with wr_valid low for 2 cycles before the second word -> IRDY high for those cycles; exactly 3 completions; no FRAME/IRDY rule violation.
- No target (DEVSEL held high), DEVSEL_TIMEOUT=5 -> abort sequence after 5 edges; done=1, status=01; bus idle.
- Reset pulsed during the third data phase of a len-6 write -> FRAME=IRDY=1, AD_oe=0 at the next edge; no done; next request runs normally.
- With PCI_INIT_PAR_EN: address 0x2 with CBE 0111 -> PAR=0 in the following cycle (four ones); data 0x1 with CBE 1111 -> PAR=1.
